mem_wb_stage: RTL and testbench

Writeback-side pipeline stage for the five-stage MIPS datapath. It latches MEM-stage results into the MEM/WB pipeline register, aligns and extends load data, and selects the final write value. It drives the register-file write port (`rd`, `writedata`, `WB_RegWrite`) one cycle after the MEM stage. It also supports stall and flush, flags misaligned loads, and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, writeback select,
// misaligned-load detection and a retired-instruction counter.
module mem_wb_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             MEM_valid,
  input  logic             MEM_RegWrite,
  input  logic [1:0]       MEM_MemtoReg,
  input  logic [2:0]       MEM_LoadType,
  input  logic [4:0]       MEM_rd,
  input  logic [WIDTH-1:0] MEM_ALUResult,
  input  logic [WIDTH-1:0] MEM_ReadData,
  input  logic [WIDTH-1:0] MEM_PC,
  output logic             WB_valid,
  output logic             WB_RegWrite,
  output logic [4:0]       WB_rd,
  output logic [WIDTH-1:0] WB_writedata,
  output logic             WB_misalign,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic             valid_q, valid_d;
  logic             rw_q, rw_d;
  logic [1:0]       mtr_q, mtr_d;
  logic [2:0]       lt_q, lt_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] pc8_q, pc8_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_en;

  assign load_en = ~flush & ~stall;

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    mtr_d   = mtr_q;
    lt_d    = lt_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc8_d   = pc8_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mtr_d   = '0;
      lt_d    = '0;
      rd_d    = '0;
      alu_d   = '0;
      rdata_d = '0;
      pc8_d   = '0;
    end else if (!stall) begin
      valid_d = MEM_valid;
      rw_d    = MEM_RegWrite;
      mtr_d   = MEM_MemtoReg;
      lt_d    = MEM_LoadType;
      rd_d    = MEM_rd;
      alu_d   = MEM_ALUResult;
      rdata_d = MEM_ReadData;
      pc8_d   = MEM_PC + WIDTH'(8);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_en && MEM_valid)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mtr_q   <= '0;
      lt_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc8_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
      lt_q    <= lt_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc8_q   <= pc8_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [1:0]       a;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_data;
  logic             misalign;

  assign a        = alu_q[1:0];
  assign byte_sel = rdata_q[8*a +: 8];
  assign half_sel = a[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    misalign  = (a != 2'b00);
    unique case (1'b1)
      lt_q == LT_LB: begin
        load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
        misalign  = 1'b0;
      end
      lt_q == LT_LBU: begin
        load_data = {{(WIDTH-8){1'b0}}, byte_sel};
        misalign  = 1'b0;
      end
      lt_q == LT_LH: begin
        load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
        misalign  = a[0];
      end
      lt_q == LT_LHU: begin
        load_data = {{(WIDTH-16){1'b0}}, half_sel};
        misalign  = a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    WB_writedata = alu_q;
    if (mtr_q == 2'b01)
      WB_writedata = load_data;
    else if (mtr_q == 2'b10)
      WB_writedata = pc8_q;
  end

  assign WB_valid      = valid_q;
  assign WB_rd         = rd_q;
  assign WB_misalign   = valid_q & (mtr_q == 2'b01) & misalign;
  assign WB_RegWrite   = valid_q & rw_q & (rd_q != 5'd0) & ~WB_misalign;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/load/link writeback,
// misalign, $0 suppression, stall/flush and counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        MEM_valid, MEM_RegWrite;
  logic [1:0]  MEM_MemtoReg;
  logic [2:0]  MEM_LoadType;
  logic [4:0]  MEM_rd;
  logic [31:0] MEM_ALUResult, MEM_ReadData, MEM_PC;
  logic        WB_valid, WB_RegWrite, WB_misalign;
  logic [4:0]  WB_rd;
  logic [31:0] WB_writedata;
  logic [3:0]  retired_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_LoadType(MEM_LoadType),
    .MEM_rd(MEM_rd), .MEM_ALUResult(MEM_ALUResult),
    .MEM_ReadData(MEM_ReadData), .MEM_PC(MEM_PC),
    .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite),
    .WB_rd(WB_rd), .WB_writedata(WB_writedata),
    .WB_misalign(WB_misalign), .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic [1:0] mtr, input logic [2:0] lt,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc);
    MEM_valid     = v;
    MEM_RegWrite  = rw;
    MEM_MemtoReg  = mtr;
    MEM_LoadType  = lt;
    MEM_rd        = rd;
    MEM_ALUResult = alu;
    MEM_ReadData  = rdata;
    MEM_PC        = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F81;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 5'd5, 32'hDEAD_BEEF, RD, 32'h100);
    tick();
    chk("rst_valid", 32'(WB_valid), 0);
    chk("rst_rw", 32'(WB_RegWrite), 0);
    chk("rst_rd", 32'(WB_rd), 0);
    chk("rst_wd", WB_writedata, 0);
    chk("rst_mis", 32'(WB_misalign), 0);
    chk("rst_cnt", 32'(retired_count), 0);

    rst = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 5'd8, 32'h1234_5678, RD, 32'h100);
    tick();
    chk("alu_rw", 32'(WB_RegWrite), 1);
    chk("alu_rd", 32'(WB_rd), 8);
    chk("alu_wd", WB_writedata, 32'h1234_5678);
    chk("alu_cnt", 32'(retired_count), 1);

    drive(1, 1, 2'b01, 3'b001, 5'd9, 32'h0000_1000, RD, 32'h104);
    tick();
    chk("lb_wd", WB_writedata, 32'hFFFF_FF81);
    chk("lb_rw", 32'(WB_RegWrite), 1);
    drive(1, 1, 2'b01, 3'b010, 5'd9, 32'h0000_1001, RD, 32'h108);
    tick();
    chk("lbu_wd", WB_writedata, 32'h0000_007F);
    drive(1, 1, 2'b01, 3'b011, 5'd9, 32'h0000_1002, RD, 32'h10C);
    tick();
    chk("lh_wd", WB_writedata, 32'hFFFF_80FF);
    chk("lh_mis", 32'(WB_misalign), 0);
    drive(1, 1, 2'b01, 3'b100, 5'd9, 32'h0000_1002, RD, 32'h110);
    tick();
    chk("lhu_wd", WB_writedata, 32'h0000_80FF);
    drive(1, 1, 2'b01, 3'b000, 5'd9, 32'h0000_1000, RD, 32'h114);
    tick();
    chk("lw_wd", WB_writedata, 32'h80FF_7F81);
    chk("lw_rw", 32'(WB_RegWrite), 1);
    chk("load_cnt", 32'(retired_count), 6);

    drive(1, 1, 2'b01, 3'b011, 5'd9, 32'h0000_1001, RD, 32'h118);
    tick();
    chk("lh_a1_mis", 32'(WB_misalign), 1);
    chk("lh_a1_rw", 32'(WB_RegWrite), 0);
    drive(1, 1, 2'b01, 3'b000, 5'd9, 32'h0000_1002, RD, 32'h11C);
    tick();
    chk("lw_a2_mis", 32'(WB_misalign), 1);
    chk("lw_a2_rw", 32'(WB_RegWrite), 0);
    drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h0000_0042, RD, 32'h120);
    tick();
    chk("r0_rw", 32'(WB_RegWrite), 0);
    chk("r0_valid", 32'(WB_valid), 1);
    chk("r0_mis", 32'(WB_misalign), 0);

    drive(1, 1, 2'b10, 3'b000, 5'd31, 32'h0000_0001, RD, 32'hFFFF_FFFC);
    tick();
    chk("link_wd", WB_writedata, 32'h0000_0004);
    chk("link_rw", 32'(WB_RegWrite), 1);
    chk("link_cnt", 32'(retired_count), 10);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b00, 3'b000, 5'd3, 32'h0BAD_0000 + i, RD, 32'h200);
      tick();
      chk("stall_wd", WB_writedata, 32'h0000_0004);
      chk("stall_rd", 32'(WB_rd), 31);
      chk("stall_rw", 32'(WB_RegWrite), 1);
      chk("stall_cnt", 32'(retired_count), 10);
    end

    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(WB_valid), 0);
    chk("flush_rw", 32'(WB_RegWrite), 0);
    chk("flush_wd", WB_writedata, 0);
    chk("flush_cnt", 32'(retired_count), 10);
    stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 2'b00, 3'b000, 5'd4, 32'h10 + i, RD, 32'h300);
      tick();
    end
    chk("pre_wrap_cnt", 32'(retired_count), 15);
    chk("pre_wrap_wd", WB_writedata, 32'h14);
    drive(0, 1, 2'b00, 3'b000, 5'd4, 32'h77, RD, 32'h300);
    tick();
    chk("bubble_cnt", 32'(retired_count), 15);
    chk("bubble_rw", 32'(WB_RegWrite), 0);
    drive(1, 1, 2'b00, 3'b000, 5'd4, 32'h88, RD, 32'h300);
    tick();
    chk("wrap_cnt", 32'(retired_count), 0);
    chk("wrap_wd", WB_writedata, 32'h88);

    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(WB_valid), 0);
    chk("rst_stall_rd", 32'(WB_rd), 0);
    chk("rst_stall_wd", WB_writedata, 0);
    chk("rst_stall_cnt", 32'(retired_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
